fifo_pipe: RTL and testbench
============================

// Module: fifo_pipe
// PURPOSE
// - Parametrised synchronous FIFO with configurable input/output register stages, for timing closure at block edges.
// - Supports show-ahead or normal read mode, almost-full/empty thresholds, and sticky overflow/underflow error flags.
// - Replaces fixed-size FIFO wrappers that hard-code one register stage each side; sits between stream producer/consumer blocks.
// PARAMETERS
// - DWIDTH             16  data word width
// - AWIDTH             4   address width; DEPTH = 2**AWIDTH words
// - SHOWAHEAD          1   1: q shows head word while !empty; 0: q updates 1 cycle after rdreq
// - ALMOST_FULL_VALUE  14  almost_full when usedw >= this; legal range 1..DEPTH
// - ALMOST_EMPTY_VALUE 2   almost_empty when usedw < this; legal range 1..DEPTH
// - IN_REGS            1   register stages on data/wrreq/rdreq (0..4)
// - OUT_REGS           1   register stages on every output (0..4)
// PORTS
// - clk_i           in   1          single clock, all logic on posedge
// - arst_n_i        in   1          asynchronous reset, active low; deassertion synchronised upstream
// - data_i          in   DWIDTH     write data
// - wrreq_i         in   1          write request
// - rdreq_i         in   1          read request / pop (show-ahead: acknowledges current q)
// - clr_err_i       in   1          synchronous clear of overflow_o/underflow_o
// - q_o             out  DWIDTH     read data
// - usedw_o         out  AWIDTH+1   occupancy 0..DEPTH
// - full_o          out  1          usedw == DEPTH
// - empty_o         out  1          usedw == 0
// - almost_full_o   out  1          usedw >= ALMOST_FULL_VALUE
// - almost_empty_o  out  1          usedw < ALMOST_EMPTY_VALUE
// - overflow_o      out  1          sticky: write attempted while full
// - underflow_o     out  1          sticky: read attempted while empty
// BEHAVIOUR
// - Reset (async, arst_n_i=0): pointers, usedw, error flags and all pipeline valid/req bits go to 0 immediately.
//   Outputs: q_o=0, usedw_o=0, full_o=0, empty_o=1, almost_full_o=0, almost_empty_o=1, overflow_o=0, underflow_o=0.
//   Storage RAM is not reset. A reset mid-operation discards all in-flight requests and stored words.
// - Latency: the request pipe delays wrreq/rdreq/data by IN_REGS cycles. The core acts on the delayed request at the next edge.
//   The output pipe delays every output by a further OUT_REGS cycles, so wrreq_i to usedw_o changes after IN_REGS+1+OUT_REGS cycles.
//   All outputs stay mutually aligned: every output reflects the same core cycle.
// - Write accepted iff core wrreq && !full; a write while full is dropped and sets overflow.
// - Read accepted iff core rdreq && !empty; a read while empty is ignored and sets underflow.
// - Simultaneous accepted read and write: usedw unchanged, both pointers advance.
// - Empty with read+write: the write is accepted and the read is rejected (underflow set).
// - Full with read+write: the read is accepted and the write is rejected (overflow set).
// - Pointers are AWIDTH bits and wrap DEPTH-1 -> 0 naturally; usedw arithmetic is AWIDTH+1 bits with no saturation needed.
// - SHOWAHEAD=1: core q = mem[rd_ptr] whenever !empty; it holds its last value when empty.
//   Write on empty: the word appears on core q 1 cycle after acceptance.
// - SHOWAHEAD=0: core q is a register loaded with mem[rd_ptr] on an accepted read; it holds otherwise.
// - Error flags: set on the offending core cycle and held until clr_err_i. If clr_err_i and a new error coincide, set wins.
// - Flow control: producers must back off on almost_full_o; ALMOST_FULL_VALUE <= DEPTH-(IN_REGS+OUT_REGS+1) guarantees no loss.
// - Elaboration $error when a threshold is out of range or IN_REGS/OUT_REGS > 4.
// STRUCTURE
// - fifo_pipe_pkg holds: a function computing the usedw width (AWIDTH+1), and a packed struct type for the flag bundle
//   (usedw, full, empty, almost_full, almost_empty, overflow, underflow) used by the output pipe.
// - Sub-module fifo_pipe_core: storage, pointers, usedw, flags, error flags; zero added latency. The wrapper adds generate-loop
//   register stages on each side (IN_REGS/OUT_REGS = 0 gives a direct wire).
// TESTING (defaults unless noted; latency L = IN_REGS+OUT_REGS+1 = 3)
// - Reset: hold arst_n_i=0 mid-burst -> outputs take reset values the same cycle;
//   after release, empty_o=1 and usedw_o=0 until the next write plus L.
// - Fill: 16 writes 0x0001..0x0010 -> usedw_o climbs to 16; almost_full_o rises at usedw 14, full_o at 16;
//   a 17th write -> usedw stays 16 and overflow_o=1 until clr_err_i.
// - Drain in show-ahead: from full, 16 reads -> q_o shows 0x0001..0x0010 in order; almost_empty_o=1 at usedw<2;
//   an extra read -> underflow_o=1.
// - Wrap: 10 writes and 10 reads, repeated 5 times with simultaneous rd+wr at usedw=5 -> data order preserved
//   across pointer wrap; usedw constant during overlap.
// - Mode/pipe sweep: SHOWAHEAD=0 with IN_REGS=0 and OUT_REGS=0, write 0xABCD then read -> q_o=0xABCD one cycle after rdreq_i;
//   repeat with IN_REGS=2 and OUT_REGS=3 -> same data, latency 6.
// - Edge races: rd+wr on empty -> usedw 1 and underflow set; rd+wr on full -> usedw 16 and overflow set;
//   clr_err_i coincident with a new error -> flag stays 1.

Source files
------------

// File: rtl/fifo_pipe_pkg.sv
// Shared types and helpers for the pipelined FIFO: usedw width and the flag bundle
// that travels through the output register stages alongside q.
package fifo_pipe_pkg;

    // The widest usedw the flag bundle can carry; AWIDTH up to 16 fits.
    localparam int USEDW_MAX = 17;

    function automatic int usedw_width(input int awidth);
        return awidth + 1;
    endfunction

    typedef struct packed {
        logic [USEDW_MAX-1:0] usedw;
        logic                 full;
        logic                 empty;
        logic                 almost_full;
        logic                 almost_empty;
        logic                 overflow;
        logic                 underflow;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{
        usedw:        '0,
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_pipe_core.sv
// FIFO storage, pointers, occupancy and sticky error flags. Every output is a register
// or decoded from one, so the core adds exactly one cycle between request and status.
module fifo_pipe_core
    import fifo_pipe_pkg::*;
#(
    parameter int DWIDTH             = 16,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 1,
    parameter int ALMOST_FULL_VALUE  = 14,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    input  logic              clr_err,
    output logic [DWIDTH-1:0] q,
    output logic [AWIDTH:0]   usedw,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int             UW      = usedw_width(AWIDTH);
    localparam int             DEPTH   = 2 ** AWIDTH;
    localparam logic [UW-1:0]  DEPTH_W = UW'(DEPTH);
    localparam logic [UW-1:0]  AF_W    = UW'(ALMOST_FULL_VALUE);
    localparam logic [UW-1:0]  AE_W    = UW'(ALMOST_EMPTY_VALUE);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_reg;
    logic [AWIDTH-1:0] rd_ptr_reg;
    logic [AWIDTH-1:0] rd_ptr_next;
    logic [UW-1:0]     usedw_reg;
    logic [UW-1:0]     usedw_next;
    logic [DWIDTH-1:0] q_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              full_now;
    logic              empty_now;
    logic              wr_acc;
    logic              rd_acc;

    assign full_now    = (usedw_reg == DEPTH_W);
    assign empty_now   = (usedw_reg == '0);
    assign wr_acc      = wrreq && !full_now;
    assign rd_acc      = rdreq && !empty_now;
    assign rd_ptr_next = rd_acc ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_comb begin
        usedw_next = usedw_reg;
        if (wr_acc && !rd_acc) begin
            usedw_next = usedw_reg + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            usedw_next = usedw_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            usedw_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            usedw_reg  <= usedw_next;
            // A new error on the same edge as a clear keeps the flag set.
            if (wrreq && full_now) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (rdreq && empty_now) begin
                underflow_reg <= 1'b1;
            end else if (clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Register the next head word; when that slot is being written on this
            // very edge the RAM still holds stale data, so take the write data instead.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (usedw_next != '0) begin
                    q_reg <= (wr_acc && (rd_ptr_next == wr_ptr_reg)) ? data : mem[rd_ptr_next];
                end
            end
        end else begin : g_normal
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (rd_acc) begin
                    q_reg <= mem[rd_ptr_reg];
                end
            end
        end
    endgenerate

    assign q            = q_reg;
    assign usedw        = usedw_reg;
    assign full         = full_now;
    assign empty        = empty_now;
    assign almost_full  = (usedw_reg >= AF_W);
    assign almost_empty = (usedw_reg < AE_W);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: rtl/fifo_pipe.sv
// Synchronous FIFO with IN_REGS request stages ahead of the core and OUT_REGS stages
// behind it; all outputs travel together so they always describe the same core cycle.
module fifo_pipe
    import fifo_pipe_pkg::*;
#(
    parameter int DWIDTH             = 16,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 1,
    parameter int ALMOST_FULL_VALUE  = 14,
    parameter int ALMOST_EMPTY_VALUE = 2,
    parameter int IN_REGS            = 1,
    parameter int OUT_REGS           = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    input  logic              clr_err_i,
    output logic [DWIDTH-1:0] q_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int UW = usedw_width(AWIDTH);

    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > (1 << AWIDTH)) begin : g_chk_af
        $error("fifo_pipe: ALMOST_FULL_VALUE %0d outside 1..%0d", ALMOST_FULL_VALUE, 1 << AWIDTH);
    end
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > (1 << AWIDTH)) begin : g_chk_ae
        $error("fifo_pipe: ALMOST_EMPTY_VALUE %0d outside 1..%0d", ALMOST_EMPTY_VALUE, 1 << AWIDTH);
    end
    if (IN_REGS < 0 || IN_REGS > 4 || OUT_REGS < 0 || OUT_REGS > 4) begin : g_chk_regs
        $error("fifo_pipe: IN_REGS=%0d OUT_REGS=%0d, each must be 0..4", IN_REGS, OUT_REGS);
    end
    if (UW > USEDW_MAX) begin : g_chk_aw
        $error("fifo_pipe: AWIDTH %0d too wide for the flag bundle", AWIDTH);
    end

    logic [DWIDTH-1:0] core_data;
    logic              core_wrreq;
    logic              core_rdreq;
    logic [DWIDTH-1:0] core_q;
    logic [AWIDTH:0]   core_usedw;
    logic              core_full;
    logic              core_empty;
    logic              core_almost_full;
    logic              core_almost_empty;
    logic              core_overflow;
    logic              core_underflow;
    flags_t            core_flags;
    logic [DWIDTH-1:0] out_q;
    flags_t            out_flags;

    genvar gi;

    // Request pipe: each stage reads the previous one, stage 0 reads the ports.
    for (gi = 0; gi < IN_REGS; gi++) begin : g_in
        logic [DWIDTH-1:0] data_prev;
        logic              wr_prev;
        logic              rd_prev;
        logic [DWIDTH-1:0] data_reg;
        logic              wr_reg;
        logic              rd_reg;
        if (gi == 0) begin : g_src
            assign data_prev = data_i;
            assign wr_prev   = wrreq_i;
            assign rd_prev   = rdreq_i;
        end else begin : g_src
            assign data_prev = g_in[gi-1].data_reg;
            assign wr_prev   = g_in[gi-1].wr_reg;
            assign rd_prev   = g_in[gi-1].rd_reg;
        end
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                data_reg <= '0;
                wr_reg   <= 1'b0;
                rd_reg   <= 1'b0;
            end else begin
                data_reg <= data_prev;
                wr_reg   <= wr_prev;
                rd_reg   <= rd_prev;
            end
        end
    end

    if (IN_REGS == 0) begin : g_in_tap
        assign core_data  = data_i;
        assign core_wrreq = wrreq_i;
        assign core_rdreq = rdreq_i;
    end else begin : g_in_tap
        assign core_data  = g_in[IN_REGS-1].data_reg;
        assign core_wrreq = g_in[IN_REGS-1].wr_reg;
        assign core_rdreq = g_in[IN_REGS-1].rd_reg;
    end

    fifo_pipe_core #(
        .DWIDTH             (DWIDTH),
        .AWIDTH             (AWIDTH),
        .SHOWAHEAD          (SHOWAHEAD),
        .ALMOST_FULL_VALUE  (ALMOST_FULL_VALUE),
        .ALMOST_EMPTY_VALUE (ALMOST_EMPTY_VALUE)
    ) u_core (
        .clk          (clk_i),
        .rst_n        (arst_n_i),
        .data         (core_data),
        .wrreq        (core_wrreq),
        .rdreq        (core_rdreq),
        .clr_err      (clr_err_i),
        .q            (core_q),
        .usedw        (core_usedw),
        .full         (core_full),
        .empty        (core_empty),
        .almost_full  (core_almost_full),
        .almost_empty (core_almost_empty),
        .overflow     (core_overflow),
        .underflow    (core_underflow)
    );

    assign core_flags = '{
        usedw:        USEDW_MAX'(core_usedw),
        full:         core_full,
        empty:        core_empty,
        almost_full:  core_almost_full,
        almost_empty: core_almost_empty,
        overflow:     core_overflow,
        underflow:    core_underflow
    };

    for (gi = 0; gi < OUT_REGS; gi++) begin : g_out
        logic [DWIDTH-1:0] q_prev;
        flags_t            flags_prev;
        logic [DWIDTH-1:0] q_reg;
        flags_t            flags_reg;
        if (gi == 0) begin : g_src
            assign q_prev     = core_q;
            assign flags_prev = core_flags;
        end else begin : g_src
            assign q_prev     = g_out[gi-1].q_reg;
            assign flags_prev = g_out[gi-1].flags_reg;
        end
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                q_reg     <= '0;
                flags_reg <= FLAGS_RESET;
            end else begin
                q_reg     <= q_prev;
                flags_reg <= flags_prev;
            end
        end
    end

    if (OUT_REGS == 0) begin : g_out_tap
        assign out_q     = core_q;
        assign out_flags = core_flags;
    end else begin : g_out_tap
        assign out_q     = g_out[OUT_REGS-1].q_reg;
        assign out_flags = g_out[OUT_REGS-1].flags_reg;
    end

    assign q_o            = out_q;
    assign usedw_o        = UW'(out_flags.usedw);
    assign full_o         = out_flags.full;
    assign empty_o        = out_flags.empty;
    assign almost_full_o  = out_flags.almost_full;
    assign almost_empty_o = out_flags.almost_empty;
    assign overflow_o     = out_flags.overflow;
    assign underflow_o    = out_flags.underflow;

endmodule

// File: tb/tb_fifo_pipe.sv
// Bench for fifo_pipe: queue-based reference model checked every cycle, a directed
// vector table, and hand sequences for fill/drain/wrap/reset and pipe-depth variants.
module tb_fifo_pipe;

    localparam int DEPTH  = 16;
    localparam int AF_VAL = 14;
    localparam int AE_VAL = 2;
    localparam int IN_LAT = 1;
    localparam int OUT_LAT = 1;

    typedef struct packed {
        logic [15:0] q;
        logic [4:0]  usedw;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        ovf;
        logic        unf;
    } snap_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] data;
    } req_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        clr;
        logic [15:0] data;
        snap_t       exp;
    } vec_t;

    localparam snap_t RESET_SNAP = '{q: 16'h0000, usedw: 5'd0, full: 1'b0, empty: 1'b1,
                                     af: 1'b0, ae: 1'b1, ovf: 1'b0, unf: 1'b0};

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters, fully model-checked.
    logic [15:0] data_a;
    logic        wr_a, rd_a, clr_a;
    logic [15:0] q_a;
    logic [4:0]  usedw_a;
    logic        full_a, empty_a, af_a, ae_a, ovf_a, unf_a;

    // Instances B (normal mode, no pipe) and C (normal mode, IN 2 / OUT 3) share inputs.
    logic [15:0] data_b;
    logic        wr_b, rd_b, clr_b;
    logic [15:0] q_b, q_c;
    logic [4:0]  usedw_b, usedw_c;
    logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic        full_c, empty_c, af_c, ae_c, ovf_c, unf_c;

    fifo_pipe dut_a (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(data_a), .wrreq_i(wr_a), .rdreq_i(rd_a),
        .clr_err_i(clr_a), .q_o(q_a), .usedw_o(usedw_a), .full_o(full_a), .empty_o(empty_a),
        .almost_full_o(af_a), .almost_empty_o(ae_a), .overflow_o(ovf_a), .underflow_o(unf_a)
    );

    fifo_pipe #(.SHOWAHEAD(0), .IN_REGS(0), .OUT_REGS(0)) dut_b (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(data_b), .wrreq_i(wr_b), .rdreq_i(rd_b),
        .clr_err_i(clr_b), .q_o(q_b), .usedw_o(usedw_b), .full_o(full_b), .empty_o(empty_b),
        .almost_full_o(af_b), .almost_empty_o(ae_b), .overflow_o(ovf_b), .underflow_o(unf_b)
    );

    fifo_pipe #(.SHOWAHEAD(0), .IN_REGS(2), .OUT_REGS(3)) dut_c (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(data_b), .wrreq_i(wr_b), .rdreq_i(rd_b),
        .clr_err_i(clr_b), .q_o(q_c), .usedw_o(usedw_c), .full_o(full_c), .empty_o(empty_c),
        .almost_full_o(af_c), .almost_empty_o(ae_c), .overflow_o(ovf_c), .underflow_o(unf_c)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: contents as a queue, requests and visible status as delay lines.
    logic [15:0] model_fifo [$];
    logic        model_ovf;
    logic        model_unf;
    logic [15:0] model_q;
    req_t        req_hist [$];
    snap_t       out_hist [$];
    snap_t       expected;

    function automatic snap_t model_snap();
        snap_t s;
        int    n;
        n       = model_fifo.size();
        s.q     = model_q;
        s.usedw = 5'(n);
        s.full  = (n == DEPTH);
        s.empty = (n == 0);
        s.af    = (n >= AF_VAL);
        s.ae    = (n < AE_VAL);
        s.ovf   = model_ovf;
        s.unf   = model_unf;
        return s;
    endfunction

    function automatic snap_t snap_a();
        snap_t s;
        s.q = q_a; s.usedw = usedw_a; s.full = full_a; s.empty = empty_a;
        s.af = af_a; s.ae = ae_a; s.ovf = ovf_a; s.unf = unf_a;
        return s;
    endfunction

    task automatic model_reset();
        req_t idle;
        idle.wr = 1'b0; idle.rd = 1'b0; idle.data = 16'h0;
        model_fifo.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        model_q   = 16'h0;
        req_hist.delete();
        out_hist.delete();
        for (int i = 0; i < IN_LAT; i++) req_hist.push_back(idle);
        for (int i = 0; i < OUT_LAT; i++) out_hist.push_back(RESET_SNAP);
        expected = RESET_SNAP;
    endtask

    task automatic model_edge();
        req_t now;
        req_t cur;
        int   n;
        now.wr = wr_a; now.rd = rd_a; now.data = data_a;
        req_hist.push_back(now);
        cur = req_hist.pop_front();
        n = model_fifo.size();
        if (cur.wr && n == DEPTH) model_ovf = 1'b1;
        else if (clr_a)           model_ovf = 1'b0;
        if (cur.rd && n == 0)     model_unf = 1'b1;
        else if (clr_a)           model_unf = 1'b0;
        if (cur.rd && n > 0)      void'(model_fifo.pop_front());
        if (cur.wr && n < DEPTH)  model_fifo.push_back(cur.data);
        if (model_fifo.size() > 0) model_q = model_fifo[0];
        out_hist.push_back(model_snap());
        expected = out_hist.pop_front();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cycle, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (arst_n) model_edge();
        cycle++;
        @(negedge clk);
        check("state_a", 64'(snap_a()), 64'(expected));
    endtask

    task automatic idle_a();
        wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        idle_a();
        model_reset();
        repeat (2) tick();
        arst_n = 1'b1;
    endtask

    vec_t tbl [9];
    int   wdata;
    int   pw;

    initial begin
        data_a = 16'h0; idle_a();
        data_b = 16'h0; wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0;
        do_reset();

        // Pipe/mode sweep on the normal-mode instances.
        data_b = 16'hABCD; wr_b = 1'b1;
        tick();
        check("b_q_before_read", 64'(q_b), 64'h0);
        check("b_usedw_after_write", 64'(usedw_b), 64'd1);
        wr_b = 1'b0; rd_b = 1'b1;
        tick();
        check("b_q_one_cycle", 64'(q_b), 64'hABCD);
        check("b_usedw_after_read", 64'(usedw_b), 64'd0);
        rd_b = 1'b0;
        repeat (4) tick();
        check("c_q_not_yet", 64'(q_c), 64'h0);
        check("c_usedw_after_write", 64'(usedw_c), 64'd1);
        tick();
        check("c_q_latency6", 64'(q_c), 64'hABCD);
        check("c_usedw_after_read", 64'(usedw_c), 64'd0);
        $display("sweep: b q=0x%04h c q=0x%04h", q_b, q_c);

        // Directed vectors: one request, then settle for the full latency.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1111, '{16'h1111, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h2222, '{16'h1111, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, '{16'h2222, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, '{16'h2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, '{16'h2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h3333, '{16'h3333, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h4444, '{16'h4444, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h4444, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        for (int r = 0; r < 9; r++) begin
            wr_a = tbl[r].wr; rd_a = tbl[r].rd; clr_a = tbl[r].clr; data_a = tbl[r].data;
            tick();
            idle_a();
            repeat (2) tick();
            check($sformatf("row%0d", r), 64'(snap_a()), 64'(tbl[r].exp));
            $display("row %0d: wr=%0b rd=%0b clr=%0b -> usedw=%0d q=0x%04h", r,
                     tbl[r].wr, tbl[r].rd, tbl[r].clr, usedw_a, q_a);
        end

        // Fill to 16, then a 17th write with clr_err_i landing on the same core cycle.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            wr_a = 1'b1; data_a = 16'(i);
            tick();
        end
        idle_a();
        repeat (2) tick();
        check("fill_usedw", 64'(usedw_a), 64'd16);
        check("fill_full", 64'(full_a), 64'd1);
        check("fill_head", 64'(q_a), 64'h0001);
        wr_a = 1'b1; data_a = 16'h0011;
        tick();
        wr_a = 1'b0; clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        repeat (2) tick();
        check("ovf_set_wins", 64'(ovf_a), 64'd1);
        check("ovf_usedw", 64'(usedw_a), 64'd16);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        repeat (2) tick();
        check("ovf_cleared", 64'(ovf_a), 64'd0);
        $display("fill: usedw=%0d full=%0b ovf=%0b", usedw_a, full_a, ovf_a);

        // Drain 16 plus one extra read.
        for (int i = 0; i < 17; i++) begin
            rd_a = 1'b1;
            tick();
        end
        idle_a();
        repeat (3) tick();
        check("drain_unf", 64'(unf_a), 64'd1);
        check("drain_q_held", 64'(q_a), 64'h0010);
        check("drain_empty", 64'(empty_a), 64'd1);
        $display("drain: usedw=%0d unf=%0b q=0x%04h", usedw_a, unf_a, q_a);
        clr_a = 1'b1;
        tick();
        idle_a();

        // Wrap: five rounds of 5 writes, 5 overlapped rd+wr, 5 reads.
        wdata = 16'h0100;
        for (int rnd = 0; rnd < 5; rnd++) begin
            for (int i = 0; i < 15; i++) begin
                wr_a = (i < 10);
                rd_a = (i >= 5);
                data_a = 16'(wdata);
                if (i < 10) wdata++;
                tick();
            end
            idle_a();
            repeat (3) tick();
            check($sformatf("wrap%0d_empty", rnd), 64'(usedw_a), 64'd0);
            $display("wrap round %0d: last q=0x%04h", rnd, q_a);
        end

        // Randomised traffic, alternating write-heavy and read-heavy phases.
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 25;
            for (int k = 0; k < 250; k++) begin
                wr_a   = ($urandom_range(99) < pw);
                rd_a   = ($urandom_range(99) < (100 - pw));
                clr_a  = ($urandom_range(99) < 3);
                data_a = 16'($urandom);
                tick();
            end
            $display("random phase %0d: usedw=%0d", ph, usedw_a);
        end
        idle_a();
        repeat (3) tick();

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) begin
            wr_a = 1'b1; data_a = 16'h0A00 + 16'(i);
            tick();
        end
        arst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", 64'(snap_a()), 64'(RESET_SNAP));
        repeat (2) tick();
        arst_n = 1'b1;
        idle_a();
        repeat (4) tick();
        check("post_reset_empty", 64'(empty_a), 64'd1);
        wr_a = 1'b1; data_a = 16'h5A5A;
        tick();
        idle_a();
        tick();
        check("post_reset_usedw_early", 64'(usedw_a), 64'd0);
        tick();
        check("post_reset_usedw_l3", 64'(usedw_a), 64'd1);
        check("post_reset_q", 64'(q_a), 64'h5A5A);
        $display("reset: usedw=%0d q=0x%04h", usedw_a, q_a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
